led_run_sequencer: RTL

//  Mode scheduler for the Flash_Run LED bank. Owns a shared tick prescaler and sequences NUM_LEDS

---
 rtl/led_seq_pkg.sv | 21 ++
 rtl/led_tick_gen.sv | 25 ++
 rtl/led_run_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - mode codes and legality check for the LED run sequencer
// Macro LED_SEQ_BOUNCE_EN makes code 100 (BOUNCE) legal.
package led_seq_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_OFF    = 3'd0;
    localparam logic [MODE_W-1:0] MODE_FLASH  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_RUN_L  = 3'd2;
    localparam logic [MODE_W-1:0] MODE_RUN_R  = 3'd3;
    localparam logic [MODE_W-1:0] MODE_BOUNCE = 3'd4;

    function automatic logic is_legal_mode(input logic [MODE_W-1:0] code);
`ifdef LED_SEQ_BOUNCE_EN
        return code <= MODE_BOUNCE;
`else
        return code <= MODE_RUN_R;
`endif
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// rtl/led_tick_gen.sv - shared prescaler producing a registered one-cycle tick every TICK_CYCLES clocks
module led_tick_gen #(
    parameter int TICK_CYCLES = 2_500_000,
    parameter int CNT_W       = 22
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_run_sequencer.sv
// rtl/led_run_sequencer.sv - LED bank mode scheduler; mode changes land on tick boundaries
// Macro LED_SEQ_BOUNCE_EN adds the BOUNCE mode and its direction register.
module led_run_sequencer
    import led_seq_pkg::*;
#(
    parameter int NUM_LEDS    = 4,
    parameter int TICK_CYCLES = 2_500_000,
    parameter int CNT_W       = 22
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                MODE_REQ,
    input  logic [MODE_W-1:0]   MODE_SEL,
    output logic                MODE_ACK,
    output logic [MODE_W-1:0]   MODE_CUR,
    output logic                TICK,
    output logic [NUM_LEDS-1:0] LED_OUT
);

    localparam logic [NUM_LEDS-1:0] LSB_ONE = NUM_LEDS'(1);
    localparam logic [NUM_LEDS-1:0] MSB_ONE = LSB_ONE << (NUM_LEDS - 1);

    logic                pending, pending_n;
    logic [MODE_W-1:0]   pend_mode, pend_mode_n;
    logic [MODE_W-1:0]   mode_n;
    logic [NUM_LEDS-1:0] led_n;
    logic                ack_n;
    logic                req_ok, apply;
`ifdef LED_SEQ_BOUNCE_EN
    logic                dir_left, dir_left_n;
`endif

    led_tick_gen #(
        .TICK_CYCLES(TICK_CYCLES),
        .CNT_W      (CNT_W)
    ) u_tick (
        .clk (CLK),
        .rst (RST),
        .tick(TICK)
    );

    always_comb begin
        req_ok      = MODE_REQ && is_legal_mode(MODE_SEL);
        apply       = TICK && pending;
        pending_n   = pending;
        pend_mode_n = pend_mode;
        mode_n      = MODE_CUR;
        led_n       = LED_OUT;
        ack_n       = apply;
`ifdef LED_SEQ_BOUNCE_EN
        dir_left_n  = dir_left;
`endif
        if (apply) begin
            mode_n    = pend_mode;
            pending_n = 1'b0;
            case (pend_mode)
                MODE_FLASH: led_n = '1;
                MODE_RUN_L: led_n = LSB_ONE;
                MODE_RUN_R: led_n = MSB_ONE;
`ifdef LED_SEQ_BOUNCE_EN
                MODE_BOUNCE: begin
                    led_n      = LSB_ONE;
                    dir_left_n = 1'b1;
                end
`endif
                default:    led_n = '0;
            endcase
        end else if (TICK) begin
            case (MODE_CUR)
                MODE_FLASH: led_n = ~LED_OUT;
                MODE_RUN_L: led_n = {LED_OUT[NUM_LEDS-2:0], LED_OUT[NUM_LEDS-1]};
                MODE_RUN_R: led_n = {LED_OUT[0], LED_OUT[NUM_LEDS-1:1]};
`ifdef LED_SEQ_BOUNCE_EN
                // Flip as the end LED is reached so each end shows for exactly one tick.
                MODE_BOUNCE: begin
                    if (dir_left) begin
                        led_n = LED_OUT << 1;
                        if (LED_OUT[NUM_LEDS-2]) dir_left_n = 1'b0;
                    end else begin
                        led_n = LED_OUT >> 1;
                        if (LED_OUT[1]) dir_left_n = 1'b1;
                    end
                end
`endif
                default:    led_n = '0;
            endcase
        end
        // A request in the apply cycle becomes the next pending request.
        if (req_ok) begin
            pending_n   = 1'b1;
            pend_mode_n = MODE_SEL;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pending   <= 1'b0;
            pend_mode <= MODE_OFF;
            MODE_CUR  <= MODE_OFF;
            LED_OUT   <= '0;
            MODE_ACK  <= 1'b0;
`ifdef LED_SEQ_BOUNCE_EN
            dir_left  <= 1'b1;
`endif
        end else begin
            pending   <= pending_n;
            pend_mode <= pend_mode_n;
            MODE_CUR  <= mode_n;
            LED_OUT   <= led_n;
            MODE_ACK  <= ack_n;
`ifdef LED_SEQ_BOUNCE_EN
            dir_left  <= dir_left_n;
`endif
        end
    end

endmodule
